// File: rtl/xbox_arb_pkg.sv
// Shared definitions for the two-requester XBOX arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default XBOX word address and data widths
//   state_t                 : arbiter ownership states
//   req_id_t                : requester identifier carried with each read
package xbox_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_ID_0 = 1'b0;
    localparam req_id_t REQ_ID_1 = 1'b1;

endpackage

// File: rtl/xbox_rd_tag_pipe.sv
// Read tag pipe: a valid+id shift register DEPTH stages long. A read pushed
// while its XBOX strobe is on the bus emerges at the tail exactly DEPTH cycles
// later, which is when the XBOX returns the matching data.
//   clk, rst  : clock, asynchronous active-high reset (clears all stages)
//   push      : a read strobe is on the XBOX bus this cycle
//   push_id   : requester that issued it
//   pop_valid : tail stage holds a read whose data is on xbox_rdata now
//   pop_id    : requester owning the tail stage
//   any_valid : at least one read is still in flight
module xbox_rd_tag_pipe
    import xbox_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_t push_id,
    output logic    pop_valid,
    output req_id_t pop_id,
    output logic    any_valid
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] id_reg;
    logic [DEPTH-1:0] id_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = push;
                assign id_next[gi]    = push_id;
            end else begin : g_tail
                assign valid_next[gi] = valid_reg[gi-1];
                assign id_next[gi]    = id_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            id_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            id_reg    <= id_next;
        end
    end

    assign pop_valid = valid_reg[DEPTH-1];
    assign pop_id    = id_reg[DEPTH-1];
    assign any_valid = |valid_reg;

endmodule

// File: rtl/xbox_arbiter.sv
// Two-requester arbiter in front of a single XBOX word port.
// Grants are combinational in the request cycle; the winning command is
// registered and appears on the XBOX bus one cycle later. Read data returns
// RD_LAT cycles after the read strobe and is steered back by a tag pipe.
//   clk, rst                 : clock, asynchronous active-high reset
//   req/wr/addr/wdata 0,1    : requester command inputs, held until granted
//   gnt0, gnt1               : request accepted this cycle
//   rvalid0, rvalid1, rdata  : read return (rdata shared by both requesters)
//   xbox_rd/wr/addr/wdata    : registered XBOX command
//   xbox_rdata               : XBOX read data
//   busy                     : an owner is held or a read is in flight
module xbox_arbiter
    import xbox_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              xbox_rd,
    output logic              xbox_wr,
    output logic [ADDR_W-1:0] xbox_addr,
    output logic [DATA_W-1:0] xbox_wdata,
    input  logic [DATA_W-1:0] xbox_rdata,
    output logic              busy
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        burst_cnt_reg;
    req_id_t           prio_reg;

    logic              xbox_rd_reg;
    logic              xbox_wr_reg;
    logic [ADDR_W-1:0] xbox_addr_reg;
    logic [DATA_W-1:0] xbox_wdata_reg;
    req_id_t           cmd_id_reg;

    logic              gnt_any;
    req_id_t           gnt_id;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              tag_valid;
    req_id_t           tag_id;
    logic              tag_any;

    // Ownership: an owner keeps the port while it requests, but yields once
    // it has used up its burst allowance and the other side is waiting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = (prio_reg == REQ_ID_1) ? OWN1 : OWN0;
                end else if (req0) begin
                    state_next = OWN0;
                end else if (req1) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_next = req1 ? OWN1 : IDLE;
                end else if (req1 && (burst_cnt_reg == BURST_LIMIT)) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_next = req0 ? OWN0 : IDLE;
                end else if (req0 && (burst_cnt_reg == BURST_LIMIT)) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt0    = (state_next == OWN0) && req0;
    assign gnt1    = (state_next == OWN1) && req1;
    assign gnt_any = gnt0 || gnt1;
    assign gnt_id  = gnt1 ? REQ_ID_1 : REQ_ID_0;

    assign sel_wr    = gnt1 ? wr1    : wr0;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Every cycle spent in an OWN state is a grant, so the counter simply
    // restarts at 1 on a change of owner and counts up to the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_reg <= 4'd0;
        end else if (state_next == IDLE) begin
            burst_cnt_reg <= 4'd0;
        end else if (state_next != state_reg) begin
            burst_cnt_reg <= 4'd1;
        end else if (burst_cnt_reg != BURST_LIMIT) begin
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
        end
    end

    // Priority goes to whichever requester was not granted last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_reg <= REQ_ID_0;
        end else if (gnt0) begin
            prio_reg <= REQ_ID_1;
        end else if (gnt1) begin
            prio_reg <= REQ_ID_0;
        end
    end

    // Command register: strobes pulse for one cycle per grant, address and
    // write data hold their last value between grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xbox_rd_reg    <= 1'b0;
            xbox_wr_reg    <= 1'b0;
            xbox_addr_reg  <= '0;
            xbox_wdata_reg <= '0;
            cmd_id_reg     <= REQ_ID_0;
        end else if (gnt_any) begin
            xbox_rd_reg    <= !sel_wr;
            xbox_wr_reg    <= sel_wr;
            xbox_addr_reg  <= sel_addr;
            xbox_wdata_reg <= sel_wdata;
            cmd_id_reg     <= gnt_id;
        end else begin
            xbox_rd_reg    <= 1'b0;
            xbox_wr_reg    <= 1'b0;
        end
    end

    assign xbox_rd    = xbox_rd_reg;
    assign xbox_wr    = xbox_wr_reg;
    assign xbox_addr  = xbox_addr_reg;
    assign xbox_wdata = xbox_wdata_reg;

    // The tag is pushed while the read strobe is on the bus, so the tail of
    // an RD_LAT-deep pipe lines up with the returning data.
    xbox_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .push      (xbox_rd_reg),
        .push_id   (cmd_id_reg),
        .pop_valid (tag_valid),
        .pop_id    (tag_id),
        .any_valid (tag_any)
    );

    assign rvalid0 = tag_valid && (tag_id == REQ_ID_0);
    assign rvalid1 = tag_valid && (tag_id == REQ_ID_1);
    assign rdata   = xbox_rdata;
    assign busy    = (state_reg != IDLE) || tag_any;

endmodule
